// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: one-outstanding SRAM-like inst bus, 1-entry skid buffer,
// branch/flush redirect handling and misaligned-PC error words.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        if_id_stall,
   input  logic        if_id_refresh,
   input  logic [31:0] flush_pc,
   input  logic        br_redirect,
   input  logic [31:0] br_slot_pc,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        id_inst_req,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] fly_pc_q, fly_pc_d;
   logic        pend_v_q, pend_v_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        cancel_q, cancel_d;
   logic        br_v_q, br_v_d;
   logic [31:0] br_tgt_q, br_tgt_d;
   logic        stop_q, stop_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_adel_q, if_adel_d;
   logic        buf_v_q, buf_v_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic        buf_adel_q, buf_adel_d;

   logic        aligned, req_up, addr_acc;
   logic        br_act, out_hit, buf_hit, fly_hit, br_none;
   logic        kill_fly, retarget, drop_buf;
   logic [31:0] new_pc;
   logic        br_v_eff;
   logic [31:0] br_tgt_eff;
   logic        data_acc, adel_go, in_v, in_adel;
   logic [31:0] in_pc, in_inst;

   assign aligned  = (fetch_pc_q[1:0] == 2'b00);
   assign req_up   = (state_q == S_REQ) && !buf_v_q && aligned;
   assign addr_acc = req_up && inst_addr_ok;

   // The delay slot is searched oldest-first: output, buffer, in-flight; anything younger is dropped.
   assign br_act   = br_redirect && !if_id_refresh;
   assign out_hit  = if_valid_q && (if_pc_q == br_slot_pc);
   assign buf_hit  = !out_hit && buf_v_q && (buf_pc_q == br_slot_pc);
   assign fly_hit  = !out_hit && !buf_hit && (state_q == S_WAIT) && !cancel_q && (fly_pc_q == br_slot_pc);
   assign br_none  = br_act && !out_hit && !buf_hit && !fly_hit;
   assign kill_fly = if_id_refresh || (br_act && (out_hit || buf_hit));
   assign retarget = if_id_refresh || (br_act && !br_none);
   assign drop_buf = br_act && out_hit;
   assign new_pc   = if_id_refresh ? flush_pc : br_target;

   assign br_v_eff   = br_none ? 1'b1 : br_v_q;
   assign br_tgt_eff = br_none ? br_target : br_tgt_q;

   assign data_acc = (state_q == S_WAIT) && inst_data_ok && !cancel_q && !kill_fly;
   assign adel_go  = (state_q == S_REQ) && !buf_v_q && !aligned && !stop_q && !if_id_refresh && !br_act;
   assign in_v     = data_acc || adel_go;
   assign in_pc    = data_acc ? fly_pc_q : fetch_pc_q;
   assign in_inst  = data_acc ? inst_rdata : 32'h0;
   assign in_adel  = !data_acc;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fly_pc_d   = fly_pc_q;
      pend_v_d   = pend_v_q;
      pend_pc_d  = pend_pc_q;
      cancel_d   = cancel_q;
      br_v_d     = br_v_eff;
      br_tgt_d   = br_tgt_eff;
      stop_d     = stop_q;
      if (adel_go) stop_d = 1'b1;
      if (retarget) begin
         stop_d = 1'b0;
         br_v_d = 1'b0;
      end
      case (state_q)
         S_REQ: begin
            if (addr_acc) begin
               state_d  = S_WAIT;
               fly_pc_d = fetch_pc_q;
               pend_v_d = 1'b0;
               if (retarget) begin
                  fetch_pc_d = new_pc;
                  cancel_d   = 1'b1;
               end else if (pend_v_q) begin
                  fetch_pc_d = pend_pc_q;
                  br_v_d     = 1'b0;
               end else if (br_v_eff) begin
                  fetch_pc_d = br_tgt_eff;
                  br_v_d     = 1'b0;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end else if (req_up) begin
               // The address on the bus must not change until accepted; redirect after it.
               if (retarget) begin
                  pend_v_d  = 1'b1;
                  pend_pc_d = new_pc;
                  cancel_d  = 1'b1;
               end
            end else if (retarget) begin
               fetch_pc_d = new_pc;
               pend_v_d   = 1'b0;
            end
         end
         S_WAIT: begin
            if (retarget) fetch_pc_d = new_pc;
            if (inst_data_ok) begin
               state_d  = S_REQ;
               cancel_d = 1'b0;
            end else if (kill_fly) begin
               cancel_d = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_adel_d  = if_adel_q;
      buf_v_d    = buf_v_q;
      buf_pc_d   = buf_pc_q;
      buf_inst_d = buf_inst_q;
      buf_adel_d = buf_adel_q;
      if (if_id_refresh) begin
         if_valid_d = 1'b0;
         buf_v_d    = 1'b0;
      end else if (!if_id_stall) begin
         buf_v_d = 1'b0;
         if (buf_v_q && !drop_buf) begin
            if_valid_d = 1'b1;
            if_pc_d    = buf_pc_q;
            if_inst_d  = buf_inst_q;
            if_adel_d  = buf_adel_q;
         end else if (in_v) begin
            if_valid_d = 1'b1;
            if_pc_d    = in_pc;
            if_inst_d  = in_inst;
            if_adel_d  = in_adel;
         end else begin
            if_valid_d = 1'b0;
         end
      end else if (in_v) begin
         if (!if_valid_q) begin
            if_valid_d = 1'b1;
            if_pc_d    = in_pc;
            if_inst_d  = in_inst;
            if_adel_d  = in_adel;
         end else begin
            buf_v_d    = 1'b1;
            buf_pc_d   = in_pc;
            buf_inst_d = in_inst;
            buf_adel_d = in_adel;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         fly_pc_q   <= 32'h0;
         pend_v_q   <= 1'b0;
         pend_pc_q  <= 32'h0;
         cancel_q   <= 1'b0;
         br_v_q     <= 1'b0;
         br_tgt_q   <= 32'h0;
         stop_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0;
         if_inst_q  <= 32'h0;
         if_adel_q  <= 1'b0;
         buf_v_q    <= 1'b0;
         buf_pc_q   <= 32'h0;
         buf_inst_q <= 32'h0;
         buf_adel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fly_pc_q   <= fly_pc_d;
         pend_v_q   <= pend_v_d;
         pend_pc_q  <= pend_pc_d;
         cancel_q   <= cancel_d;
         br_v_q     <= br_v_d;
         br_tgt_q   <= br_tgt_d;
         stop_q     <= stop_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_adel_q  <= if_adel_d;
         buf_v_q    <= buf_v_d;
         buf_pc_q   <= buf_pc_d;
         buf_inst_q <= buf_inst_d;
         buf_adel_q <= buf_adel_d;
      end
   end

   // Request is held low while reset is asserted.
   assign inst_req    = resetn && req_up;
   assign inst_addr   = fetch_pc_q;
   assign id_inst_req = (state_q == S_WAIT);
   assign if_valid    = if_valid_q;
   assign if_pc       = if_pc_q;
   assign if_inst     = if_inst_q;
   assign if_adel     = if_adel_q;

endmodule
